// File: rtl/gumnut_timer_pkg.sv
// Shared constants for the Gumnut port-bus interval timer.
// Holds the register offsets inside the 4-byte window, the CTRL/STATUS bit positions
// and the reset values of RELOAD/COUNT.
// Optional feature macro: GUMNUT_TIMER_OVF_EN adds the STATUS[1] overflow flag.
package gumnut_timer_pkg;

  localparam int unsigned DW = 8;

  // Register offsets within the window
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_RELOAD = 2'd2;
  localparam logic [1:0] REG_COUNT  = 2'd3;

  // CTRL bit positions
  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_IE   = 1;
  localparam int unsigned CTRL_AUTO = 2;
  localparam int unsigned CTRL_W    = 3;

  // STATUS bit positions
  localparam int unsigned STAT_TF  = 0;
  localparam int unsigned STAT_OVF = 1;

  localparam logic [DW-1:0] RELOAD_RST = 8'hFF;
  localparam logic [DW-1:0] COUNT_RST  = 8'hFF;

endpackage

// File: rtl/gumnut_timer_prescaler.sv
// Clock prescaler for the Gumnut timer.
// Counts 0..PRESCALE-1 while enabled and flags the terminal value as a tick.
// Ports:
//   clk_i     clock
//   rst_i     asynchronous active-low reset
//   en_i      count enable; counter is held at 0 while low
//   clr_i     synchronous clear back to 0
//   tick_c_o  combinational tick, high during the cycle the counter sits on its terminal value
module gumnut_timer_prescaler #(
  parameter int unsigned PRESCALE = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_c_o
);

  // PRESCALE of 1 still needs a one-bit counter
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] TERM = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  assign tick_c_o = en_i & (cnt_q == TERM);

  // Next count: hold at 0 when disabled/cleared, wrap after the tick
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || clr_i) begin
      cnt_d = '0;
    end else if (tick_c_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gumnut_port_timer.sv
// Programmable interval timer slave on the Gumnut CPU I/O port bus.
// Decodes a 4-register window (CTRL, STATUS, RELOAD, COUNT), counts prescaled ticks,
// raises int_req_o while the expired flag and interrupt enable are both set, and
// clears the flag on int_ack_i.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-low reset
//   cyc_i, stb_i, we_i      bus cycle, strobe, write enable
//   adr_i[7:0], dat_i[7:0]  port address, write data
//   ack_o                   one-cycle acknowledge per transfer
//   dat_o[7:0]              read data, zero outside a read acknowledge
//   int_req_o               level interrupt request
//   int_ack_i               single-cycle interrupt acknowledge
// Optional feature macro: GUMNUT_TIMER_OVF_EN (STATUS[1] overflow flag).
module gumnut_port_timer
  import gumnut_timer_pkg::*;
#(
  parameter logic [7:0]  BASE_ADR = 8'h10,
  parameter int unsigned PRESCALE = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cyc_i,
  input  logic          stb_i,
  input  logic          we_i,
  input  logic [7:0]    adr_i,
  input  logic [DW-1:0] dat_i,
  output logic          ack_o,
  output logic [DW-1:0] dat_o,
  output logic          int_req_o,
  input  logic          int_ack_i
);

  logic              ack_q, ack_d;
  logic [DW-1:0]     dat_q, dat_d;
  logic              irq_q, irq_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              tf_q, tf_d;
  logic [DW-1:0]     reload_q, reload_d;
  logic [DW-1:0]     count_q, count_d;
`ifdef GUMNUT_TIMER_OVF_EN
  logic              ovf_q, ovf_d;
`endif

  logic          sel_c, acc_c, wr_c, rd_c;
  logic [1:0]    off_c;
  logic          tick_c, expire_c, pre_clr_c;
  logic [DW-1:0] rdata_c;

  // Bus decode; an access happens only on the cycle that raises ack
  assign sel_c    = cyc_i & stb_i & (adr_i[7:2] == BASE_ADR[7:2]);
  assign acc_c    = sel_c & ~ack_q;
  assign wr_c     = acc_c & we_i;
  assign rd_c     = acc_c & ~we_i;
  assign off_c    = adr_i[1:0];
  assign expire_c = tick_c & (count_q == '0);

  gumnut_timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (ctrl_q[CTRL_EN]),
    .clr_i    (pre_clr_c),
    .tick_c_o (tick_c)
  );

  // Read mux over current register contents
  always_comb begin
    rdata_c = '0;
    case (off_c)
      REG_CTRL:   rdata_c = DW'(ctrl_q);
      REG_STATUS: begin
        rdata_c[STAT_TF] = tf_q;
`ifdef GUMNUT_TIMER_OVF_EN
        rdata_c[STAT_OVF] = ovf_q;
`endif
      end
      REG_RELOAD: rdata_c = reload_q;
      REG_COUNT:  rdata_c = count_q;
      default:    rdata_c = '0;
    endcase
  end

  // Next-state: counter/expiry first, then flag clears/sets, then bus writes override
  always_comb begin
    ctrl_d    = ctrl_q;
    tf_d      = tf_q;
    reload_d  = reload_q;
    count_d   = count_q;
    pre_clr_c = 1'b0;
`ifdef GUMNUT_TIMER_OVF_EN
    ovf_d     = ovf_q;
`endif

    if (tick_c) begin
      if (count_q != '0) begin
        count_d = count_q - DW'(1);
      end else if (ctrl_q[CTRL_AUTO]) begin
        count_d = reload_q;
      end else begin
        ctrl_d[CTRL_EN] = 1'b0;
      end
    end

    // Expiry set wins over ack/W1C clear on the same edge
    if (int_ack_i || (wr_c && (off_c == REG_STATUS) && dat_i[STAT_TF])) begin
      tf_d = 1'b0;
    end
`ifdef GUMNUT_TIMER_OVF_EN
    if (wr_c && (off_c == REG_STATUS) && dat_i[STAT_OVF]) begin
      ovf_d = 1'b0;
    end
    if (expire_c && tf_q) begin
      ovf_d = 1'b1;
    end
`endif
    if (expire_c) begin
      tf_d = 1'b1;
    end

    if (wr_c) begin
      case (off_c)
        REG_CTRL: begin
          ctrl_d    = dat_i[CTRL_W-1:0];
          pre_clr_c = ~ctrl_q[CTRL_EN] & dat_i[CTRL_EN];
        end
        REG_RELOAD: reload_d = dat_i;
        REG_COUNT: begin
          count_d   = dat_i;
          pre_clr_c = 1'b1;
        end
        default: ;
      endcase
    end

    ack_d = acc_c;
    dat_d = rd_c ? rdata_c : '0;
    irq_d = tf_q & ctrl_q[CTRL_IE];
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      irq_q    <= 1'b0;
      ctrl_q   <= '0;
      tf_q     <= 1'b0;
      reload_q <= RELOAD_RST;
      count_q  <= COUNT_RST;
`ifdef GUMNUT_TIMER_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      irq_q    <= irq_d;
      ctrl_q   <= ctrl_d;
      tf_q     <= tf_d;
      reload_q <= reload_d;
      count_q  <= count_d;
`ifdef GUMNUT_TIMER_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign ack_o     = ack_q;
  assign dat_o     = dat_q;
  assign int_req_o = irq_q;

endmodule
